adc_multilane_capture: RTL and testbench

Parametrised successor to the single-lane ADC serial capture path: deserialises NUM_LANES parallel ADC data lines clocked by the ADC's own serial clock and data-ready strobe, and streams tagged per-lane sample words into the shared sample FIFO. It sits between the ADC pins and the FIFO write port. It runs on the 84 MHz system clock, with start/enable and lane mask driven by the SPI/command controller. It adds per-lane masking, frame tagging, FIFO back-pressure and overrun accounting.

---
 rtl/adc_capture_pkg.sv | 15 +
 rtl/adc_input_synchronizer.sv | 40 ++++
 rtl/adc_multilane_capture.sv | 155 +++++++++++++++
 tb/tb_adc_multilane_capture.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the multi-lane ADC capture path.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT,
    EMIT
  } capture_state_t;

  localparam int unsigned HEADER_BITS   = 8;
  localparam int unsigned LANE_IDX_BITS = 4;
  localparam logic [7:0]  OVERRUN_MAX   = 8'hFF;

endpackage

// File: rtl/adc_input_synchronizer.sv
// Synchronises DRDY, serial clock and lane data through one common flop chain
// so all three stay aligned; produces registered edge pulses from the synced copies.
module adc_input_synchronizer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LANES       = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             drdy,
  input  logic             sclk,
  input  logic [LANES-1:0] data,
  output logic [LANES-1:0] data_sync,
  output logic             sclk_rise,
  output logic             drdy_fall
);

  localparam int unsigned WIDTH = LANES + 2;

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] last_q;

  // last_q holds the value the edge pulse refers to, so data_sync lines up with sclk_rise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      last_q    <= '0;
      sclk_rise <= 1'b0;
      drdy_fall <= 1'b0;
    end else begin
      stage_q[0] <= {data, sclk, drdy};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      last_q    <= stage_q[SYNC_STAGES-1];
      sclk_rise <= stage_q[SYNC_STAGES-1][1] & ~last_q[1];
      drdy_fall <= ~stage_q[SYNC_STAGES-1][0] & last_q[0];
    end
  end

  assign data_sync = last_q[WIDTH-1:2];

endmodule

// File: rtl/adc_multilane_capture.sv
// Multi-lane ADC deserialiser: captures one SAMPLE_BITS word per lane per DRDY
// frame and streams tagged words for the masked lanes into the sample FIFO.
module adc_multilane_capture
  import adc_capture_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned SAMPLE_BITS = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic [NUM_LANES-1:0]               lane_mask,
  input  logic                               adc_data_ready,
  input  logic                               adc_clock,
  input  logic [NUM_LANES-1:0]               adc_data,
  input  logic                               buffer_full,
  output logic [SAMPLE_BITS+HEADER_BITS-1:0] adc_channel_data,
  output logic                               buffer_write_enable,
  output logic                               busy,
  output logic [3:0]                         frame_seq,
  output logic [7:0]                         overrun_count
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_BITS + 1);

  capture_state_t state_q, state_d;

  logic [NUM_LANES-1:0]     data_sync;
  logic                     sclk_rise;
  logic                     drdy_fall;
  logic [CNT_W-1:0]         bit_cnt_q;
  logic [SAMPLE_BITS-1:0]   shift_q [NUM_LANES];
  logic [SAMPLE_BITS-1:0]   hold_q  [NUM_LANES];
  logic [NUM_LANES-1:0]     mask_q;
  logic [NUM_LANES-1:0]     pending_q;
  logic [3:0]               tag_q;

  logic                     start_frame, shift_en, capture, overrun, found;
  logic [NUM_LANES-1:0]     write_sel;
  logic [LANE_IDX_BITS-1:0] lane_tag;
  logic [SAMPLE_BITS-1:0]   sample;

  adc_input_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES),
    .LANES      (NUM_LANES)
  ) u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .drdy     (adc_data_ready),
    .sclk     (adc_clock),
    .data     (adc_data),
    .data_sync(data_sync),
    .sclk_rise(sclk_rise),
    .drdy_fall(drdy_fall)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    capture     = 1'b0;
    overrun     = 1'b0;
    found       = 1'b0;
    write_sel   = '0;
    lane_tag    = '0;
    sample      = '0;
    // lowest pending lane goes first, giving ascending lane order
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!found && pending_q[i]) begin
        found        = 1'b1;
        write_sel[i] = 1'b1;
        lane_tag     = LANE_IDX_BITS'(i);
        sample       = hold_q[i];
      end
    end
    buffer_write_enable = (state_q == EMIT) && found && !buffer_full;
    adc_channel_data    = {tag_q, lane_tag, sample};
    busy                = (state_q != IDLE);

    case (state_q)
      IDLE:  if (enable) state_d = ARMED;
      ARMED: begin
        if (!enable) state_d = IDLE;
        else if (drdy_fall) begin
          start_frame = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (drdy_fall) begin
          overrun     = 1'b1;
          start_frame = 1'b1;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt_q == CNT_W'(SAMPLE_BITS - 1)) begin
            capture = 1'b1;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        overrun = drdy_fall;
        if (!found || (buffer_write_enable && (pending_q & ~write_sel) == '0))
          state_d = enable ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q     <= '0;
      mask_q        <= '0;
      pending_q     <= '0;
      tag_q         <= '0;
      frame_seq     <= '0;
      overrun_count <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        shift_q[i] <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      if (start_frame) begin
        bit_cnt_q <= '0;
        mask_q    <= lane_mask;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (shift_en)
        for (int unsigned i = 0; i < NUM_LANES; i++)
          shift_q[i] <= {shift_q[i][SAMPLE_BITS-2:0], data_sync[i]};

      if (capture) begin
        for (int unsigned i = 0; i < NUM_LANES; i++)
          hold_q[i] <= {shift_q[i][SAMPLE_BITS-2:0], data_sync[i]};
        pending_q <= mask_q;
        tag_q     <= frame_seq;
        frame_seq <= frame_seq + 1'b1;
      end else if (buffer_write_enable) begin
        pending_q <= pending_q & ~write_sel;
      end

      if (overrun && overrun_count != OVERRUN_MAX)
        overrun_count <= overrun_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_multilane_capture.sv
// Self-checking bench for adc_multilane_capture: fixed frame table, randomized
// frames against a frame-level reference model, and multi-cycle corner cases.
module tb_adc_multilane_capture;

  localparam int unsigned NL = 4;
  localparam int unsigned SB = 24;
  localparam int unsigned SS = 2;

  typedef logic [NL-1:0][SB-1:0] lanes_t;
  typedef struct packed {
    logic [3:0]        mask;
    lanes_t            samples;
    logic [3:0][31:0]  words;
    logic [2:0]        nwords;
    logic [3:0]        seq_after;
  } vec_t;

  logic          clock;
  logic          reset_n;
  logic          enable;
  logic [NL-1:0] lane_mask;
  logic          adc_data_ready;
  logic          adc_clock;
  logic [NL-1:0] adc_data;
  logic          buffer_full;
  logic [SB+7:0] adc_channel_data;
  logic          buffer_write_enable;
  logic          busy;
  logic [3:0]    frame_seq;
  logic [7:0]    overrun_count;

  adc_multilane_capture #(
    .NUM_LANES  (NL),
    .SAMPLE_BITS(SB),
    .SYNC_STAGES(SS)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .enable             (enable),
    .lane_mask          (lane_mask),
    .adc_data_ready     (adc_data_ready),
    .adc_clock          (adc_clock),
    .adc_data           (adc_data),
    .buffer_full        (buffer_full),
    .adc_channel_data   (adc_channel_data),
    .buffer_write_enable(buffer_write_enable),
    .busy               (busy),
    .frame_seq          (frame_seq),
    .overrun_count      (overrun_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q [$];
  int          m_seq = 0;
  int          exp_ovr = 0;
  int          full_writes = 0;
  vec_t        tbl [5];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write is matched against the reference queue in order.
  always @(negedge clock) begin
    if (reset_n && buffer_write_enable) begin
      if (buffer_full) full_writes++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got %08h, expected no write", adc_channel_data);
      end else begin
        check("write_word", adc_channel_data, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic drdy_pulse();
    adc_data_ready = 1'b0;
    step(4);
    adc_data_ready = 1'b1;
    step(4);
  endtask

  task automatic send_bits(input lanes_t s, input int from, input int to);
    for (int b = from; b < to; b++) begin
      for (int i = 0; i < NL; i++) adc_data[i] = s[i][SB-1-b];
      adc_clock = 1'b0;
      step(4);
      adc_clock = 1'b1;
      step(4);
    end
    adc_clock = 1'b0;
    step(4);
  endtask

  task automatic full_frame(input logic [3:0] mask, input lanes_t s);
    lane_mask = mask;
    drdy_pulse();
    send_bits(s, 0, SB);
  endtask

  // Frame-level reference: one tagged word per masked lane, ascending lane order.
  task automatic model_frame(input logic [3:0] mask, input lanes_t s);
    for (int i = 0; i < NL; i++)
      if (mask[i]) exp_q.push_back({4'(m_seq), 4'(i), s[i]});
    m_seq = (m_seq + 1) % 16;
  endtask

  task automatic wait_drain(input int budget);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < budget) begin
      step(1);
      cnt++;
    end
    check("drain_pending_words", exp_q.size(), 0);
  endtask

  function automatic lanes_t rand_lanes();
    lanes_t r;
    for (int i = 0; i < NL; i++) r[i] = SB'($urandom);
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] mask,
                              input logic [23:0] s0, s1, s2, s3,
                              input logic [31:0] w0, w1, w2, w3,
                              input int n, input int seq);
    vec_t v;
    v.mask       = mask;
    v.samples[0] = s0; v.samples[1] = s1; v.samples[2] = s2; v.samples[3] = s3;
    v.words[0]   = w0; v.words[1]   = w1; v.words[2]   = w2; v.words[3]   = w3;
    v.nwords     = 3'(n);
    v.seq_after  = 4'(seq);
    return v;
  endfunction

  initial begin
    lanes_t s, s2;

    tbl[0] = mk(4'b1111, 24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF,
                32'h00123456, 32'h01ABCDEF, 32'h02000001, 32'h03FFFFFF, 4, 1);
    tbl[1] = mk(4'b1010, 24'h111111, 24'h222222, 24'h333333, 24'h444444,
                32'h11222222, 32'h13444444, 32'h0, 32'h0, 2, 2);
    tbl[2] = mk(4'b0000, 24'hAAAAAA, 24'h555555, 24'hAAAAAA, 24'h555555,
                32'h0, 32'h0, 32'h0, 32'h0, 0, 3);
    tbl[3] = mk(4'b1000, 24'h000000, 24'h000000, 24'h000000, 24'h800001,
                32'h33800001, 32'h0, 32'h0, 32'h0, 1, 4);
    tbl[4] = mk(4'b0001, 24'h5A5A5A, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                32'h405A5A5A, 32'h0, 32'h0, 32'h0, 1, 5);

    reset_n        = 1'b0;
    enable         = 1'b0;
    adc_data_ready = 1'b1;
    adc_clock      = 1'b0;
    adc_data       = '0;
    buffer_full    = 1'b0;
    lane_mask      = '0;
    step(3);
    check("reset_data", adc_channel_data, 0);
    check("reset_wen", buffer_write_enable, 0);
    check("reset_busy", busy, 0);
    check("reset_seq", frame_seq, 0);
    check("reset_overrun", overrun_count, 0);

    reset_n = 1'b1;
    enable  = 1'b1;
    step(4);
    check("armed_busy", busy, 1);

    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < int'(tbl[k].nwords); w++) exp_q.push_back(tbl[k].words[w]);
      full_frame(tbl[k].mask, tbl[k].samples);
      wait_drain(100);
      check("table_frame_seq", frame_seq, tbl[k].seq_after);
      m_seq = int'(tbl[k].seq_after);
    end

    // 17 frames on lanes 1 and 3: header sequence wraps through 15 -> 0
    for (int f = 0; f < 17; f++) begin
      s = rand_lanes();
      model_frame(4'b1010, s);
      full_frame(4'b1010, s);
      wait_drain(100);
    end
    check("wrap_frame_seq", frame_seq, m_seq);

    for (int f = 0; f < 8; f++) begin
      logic [3:0] m;
      m = 4'($urandom);
      s = rand_lanes();
      model_frame(m, s);
      full_frame(m, s);
      wait_drain(100);
    end
    check("random_frame_seq", frame_seq, m_seq);

    // back-pressure held through EMIT with a DRDY edge arriving meanwhile
    buffer_full = 1'b1;
    full_writes = 0;
    s = rand_lanes();
    model_frame(4'b1111, s);
    full_frame(4'b1111, s);
    step(10);
    drdy_pulse();
    exp_ovr++;
    step(32);
    check("no_write_while_full", full_writes, 0);
    check("held_words_pending", exp_q.size(), 4);
    check("backpressure_busy", busy, 1);
    check("backpressure_overrun", overrun_count, exp_ovr);
    buffer_full = 1'b0;
    wait_drain(100);

    // DRDY after 10 of 24 bits: partial frame dropped, next full frame captured
    s  = rand_lanes();
    s2 = rand_lanes();
    lane_mask = 4'b1111;
    drdy_pulse();
    send_bits(s, 0, 10);
    drdy_pulse();
    exp_ovr++;
    model_frame(4'b1111, s2);
    send_bits(s2, 0, SB);
    wait_drain(100);
    check("abort_overrun", overrun_count, exp_ovr);
    check("abort_frame_seq", frame_seq, m_seq);

    // enable dropped mid-SHIFT: frame still emitted, then idle
    s = rand_lanes();
    model_frame(4'b0111, s);
    lane_mask = 4'b0111;
    drdy_pulse();
    send_bits(s, 0, 12);
    enable = 1'b0;
    send_bits(s, 12, SB);
    wait_drain(100);
    step(3);
    check("disable_busy", busy, 0);
    full_frame(4'b1111, rand_lanes());
    step(10);
    check("disabled_busy", busy, 0);
    check("disabled_frame_seq", frame_seq, m_seq);

    // reset pulsed mid-SHIFT
    enable = 1'b1;
    step(3);
    lane_mask = 4'b1111;
    drdy_pulse();
    send_bits(rand_lanes(), 0, 12);
    reset_n = 1'b0;
    step(1);
    check("midreset_data", adc_channel_data, 0);
    check("midreset_wen", buffer_write_enable, 0);
    check("midreset_busy", busy, 0);
    check("midreset_seq", frame_seq, 0);
    check("midreset_overrun", overrun_count, 0);
    reset_n = 1'b1;
    exp_q.delete();
    m_seq   = 0;
    exp_ovr = 0;
    step(4);
    s = rand_lanes();
    model_frame(4'b1111, s);
    full_frame(4'b1111, s);
    wait_drain(100);
    check("post_reset_seq", frame_seq, 1);

    // overrun counter saturates
    buffer_full = 1'b1;
    s = rand_lanes();
    model_frame(4'b1001, s);
    full_frame(4'b1001, s);
    for (int p = 0; p < 260; p++) begin
      drdy_pulse();
      if (exp_ovr < 255) exp_ovr++;
    end
    check("overrun_saturate", overrun_count, exp_ovr);
    buffer_full = 1'b0;
    wait_drain(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
